// File: rtl/alu_pkg.sv
// Shared types for the pipelined adder/subtractor: operation encoding and ALU flag bundle.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } aluop_t;

    typedef struct packed {
        logic vldflg;
        logic cryflg;
        logic ngtflg;
        logic zroflg;
    } flags_t;

endpackage

// File: rtl/addsub_slice.sv
// One combinational carry-chain slice: a + (b ^ mode) + cin over SW bits.
module addsub_slice #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          mode,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          c_msb_in
);

    logic [SW-1:0] bx;

    always_comb begin
        bx          = b ^ {SW{mode}};
        {cout, s}   = {1'b0, a} + {1'b0, bx} + {{SW{1'b0}}, cin};
        // carry into the top bit recovered from the sum bit: s = a ^ bx ^ c
        c_msb_in    = s[SW-1] ^ a[SW-1] ^ bx[SW-1];
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub with elastic per-stage handshake; one carry slice per stage,
// operands skew forward, lower result bits accumulate, flags formed in the last stage.
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             vldflg,
    output logic             cryflg,
    output logic             ngtflg,
    output logic             zroflg
);

    localparam int SW = WIDTH / STAGES;

    logic [STAGES-1:0] vld_q, vld_d, en, up_vld;
    logic [STAGES:0]   adv;

    // adv[k]: stage k takes a new value this edge; adv[STAGES] is the consumer.
    always_comb begin
        adv         = '0;
        vld_d       = '0;
        en          = '0;
        up_vld      = STAGES'({vld_q, in_valid});
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !vld_q[k] || adv[k+1];
        end
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = flush ? 1'b0 : (adv[k] ? up_vld[k] : vld_q[k]);
            en[k]    = adv[k] && up_vld[k] && !flush;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[STAGES-1];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) vld_q <= '0;
        else       vld_q <= vld_d;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int HI  = (k + 1) * SW;
        localparam int RIN = WIDTH - k * SW;

        logic [RIN-1:0] ua, ub;
        logic           um, uc;
        logic [SW-1:0]  ss;
        logic           scout, smsb;
        logic [HI-1:0]  sum_d, sum_q;

        if (k == 0) begin : g_src
            assign ua    = a;
            assign ub    = b;
            assign um    = mode;
            assign uc    = mode;
            assign sum_d = ss;
        end else begin : g_src
            assign ua    = g_stg[k-1].g_fwd.opa_q;
            assign ub    = g_stg[k-1].g_fwd.opb_q;
            assign um    = g_stg[k-1].g_fwd.mode_q;
            assign uc    = g_stg[k-1].g_fwd.cry_q;
            assign sum_d = {ss, g_stg[k-1].sum_q};
        end

        addsub_slice #(.SW(SW)) u_slice (
            .a        (ua[SW-1:0]),
            .b        (ub[SW-1:0]),
            .mode     (um),
            .cin      (uc),
            .s        (ss),
            .cout     (scout),
            .c_msb_in (smsb)
        );

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST)      sum_q <= '0;
            else if (en[k]) sum_q <= sum_d;
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int REM = WIDTH - HI;

            logic [REM-1:0] opa_d, opa_q, opb_d, opb_q;
            aluop_t         mode_d, mode_q;
            logic           cry_d, cry_q;

            always_comb begin
                opa_d  = ua[RIN-1:SW];
                opb_d  = ub[RIN-1:SW];
                mode_d = aluop_t'(um);
                cry_d  = scout;
            end

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    opa_q  <= '0;
                    opb_q  <= '0;
                    mode_q <= ADD;
                    cry_q  <= 1'b0;
                end else if (en[k]) begin
                    opa_q  <= opa_d;
                    opb_q  <= opb_d;
                    mode_q <= mode_d;
                    cry_q  <= cry_d;
                end
            end
        end else begin : g_fin
            flags_t flags_d, flags_q;

            // scout is c[WIDTH], smsb is c[WIDTH-1] of the full chain
            always_comb begin
                flags_d        = '0;
                flags_d.vldflg = scout ^ smsb;
                flags_d.cryflg = um ^ scout;
                flags_d.ngtflg = sum_d[WIDTH-1];
                flags_d.zroflg = ~|sum_d;
            end

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST)      flags_q <= '0;
                else if (en[k]) flags_q <= flags_d;
            end

            assign result = sum_q;
            assign vldflg = flags_q.vldflg;
            assign cryflg = flags_q.cryflg;
            assign ngtflg = flags_q.ngtflg;
            assign zroflg = flags_q.zroflg;
        end
    end

endmodule
